// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic inter-stage pipeline register driven by the central
//            stall vector. Supports flush, a one-entry skid buffer, a valid
//            bit, a sticky side flag and saturating stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                   PAYLOAD_W   = 109,
    parameter int                   STALL_W     = 6,
    parameter int                   STAGE_IDX   = 2,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
    parameter int                   SKID_EN     = 1,
    parameter int                   CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_side,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_side,
    output logic                 skid_valid,
    output logic                 overflow,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    // The output stall bit must exist inside the stall vector.
    generate
        if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
        end
    endgenerate

    // Skid capability resolved at elaboration; without it every capture
    // attempt turns into a dropped input.
    logic w_skid_en;
    generate
        if (SKID_EN != 0) begin : g_skid_on
            assign w_skid_en = 1'b1;
        end else begin : g_skid_off
            assign w_skid_en = 1'b0;
        end
    endgenerate

    logic w_si;
    logic w_so;
    assign w_si = stall[STAGE_IDX];
    assign w_so = stall[STAGE_IDX+1];

    // Only two bits of the stall vector belong to this stage.
    logic w_unused_stall;
    assign w_unused_stall = ^stall;

    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 valid_q,   valid_d;
    logic                 side_q,    side_d;
    logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
    logic                 skid_v_q,       skid_v_d;
    logic                 skid_side_q,    skid_side_d;
    logic                 skid_full_q,    skid_full_d;
    logic                 overflow_q,     overflow_d;
    logic [CNT_W-1:0]     bubble_cnt_q,   bubble_cnt_d;
    logic [CNT_W-1:0]     stall_cnt_q,    stall_cnt_d;
    logic                 w_bubble_inc;
    logic                 w_stall_inc;

    // Next-state selection in priority order: flush, upstream-only stall,
    // free flow, downstream-only stall, full stall.
    always_comb begin
        payload_d      = payload_q;
        valid_d        = valid_q;
        side_d         = side_q;
        skid_payload_d = skid_payload_q;
        skid_v_d       = skid_v_q;
        skid_side_d    = skid_side_q;
        skid_full_d    = skid_full_q;
        overflow_d     = overflow_q;
        w_bubble_inc   = 1'b0;
        w_stall_inc    = 1'b0;

        if (flush) begin
            payload_d   = NOP_PAYLOAD;
            valid_d     = 1'b0;
            side_d      = 1'b0;
            skid_full_d = 1'b0;
        end else if (w_si && !w_so) begin
            if (skid_full_q) begin
                payload_d   = skid_payload_q;
                valid_d     = skid_v_q;
                side_d      = skid_side_q;
                skid_full_d = 1'b0;
            end else begin
                // Bubble: the side flag is deliberately left alone.
                payload_d    = NOP_PAYLOAD;
                valid_d      = 1'b0;
                w_bubble_inc = 1'b1;
            end
        end else if (!w_si && !w_so) begin
            if (skid_full_q) begin
                // Drain the older entry first and refill behind it.
                payload_d      = skid_payload_q;
                valid_d        = skid_v_q;
                side_d         = skid_side_q;
                skid_payload_d = in_payload;
                skid_v_d       = in_valid;
                skid_side_d    = in_side;
            end else begin
                payload_d = in_payload;
                valid_d   = in_valid;
                side_d    = in_side;
            end
        end else if (!w_si && w_so) begin
            w_stall_inc = 1'b1;
            if (!skid_full_q && w_skid_en) begin
                skid_payload_d = in_payload;
                skid_v_d       = in_valid;
                skid_side_d    = in_side;
                skid_full_d    = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else begin
            w_stall_inc = 1'b1;
        end

        if (cnt_clr) begin
            bubble_cnt_d = '0;
            stall_cnt_d  = '0;
        end else begin
            bubble_cnt_d = (w_bubble_inc && !(&bubble_cnt_q)) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
            stall_cnt_d  = (w_stall_inc  && !(&stall_cnt_q))  ? stall_cnt_q  + CNT_W'(1) : stall_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload_q      <= NOP_PAYLOAD;
            valid_q        <= 1'b0;
            side_q         <= 1'b0;
            skid_payload_q <= '0;
            skid_v_q       <= 1'b0;
            skid_side_q    <= 1'b0;
            skid_full_q    <= 1'b0;
            overflow_q     <= 1'b0;
            bubble_cnt_q   <= '0;
            stall_cnt_q    <= '0;
        end else begin
            payload_q      <= payload_d;
            valid_q        <= valid_d;
            side_q         <= side_d;
            skid_payload_q <= skid_payload_d;
            skid_v_q       <= skid_v_d;
            skid_side_q    <= skid_side_d;
            skid_full_q    <= skid_full_d;
            overflow_q     <= overflow_d;
            bubble_cnt_q   <= bubble_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign out_payload = payload_q;
    assign out_valid   = valid_q;
    assign out_side    = side_q;
    assign skid_valid  = skid_full_q;
    assign overflow    = overflow_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg (vector table plus
//            hand sequences for counter saturation and async reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int PW = 16;
    localparam int SW = 6;

    logic          clk;
    logic          rst;
    logic [SW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_payload;
    logic          in_side;
    logic          cnt_clr;

    logic          out_valid,  out_valid2;
    logic [PW-1:0] out_payload, out_payload2;
    logic          out_side,   out_side2;
    logic          skid_valid, skid_valid2;
    logic          overflow,   overflow2;
    logic [15:0]   bubble_cnt, stall_cnt;
    logic [1:0]    bubble_cnt2, stall_cnt2;

    pipe_stage_reg #(.PAYLOAD_W(PW), .STALL_W(SW), .STAGE_IDX(2),
                     .NOP_PAYLOAD('0), .SKID_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_side(in_side),
        .out_valid(out_valid), .out_payload(out_payload), .out_side(out_side),
        .skid_valid(skid_valid), .overflow(overflow), .cnt_clr(cnt_clr),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.PAYLOAD_W(PW), .STALL_W(SW), .STAGE_IDX(2),
                     .NOP_PAYLOAD('0), .SKID_EN(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_side(in_side),
        .out_valid(out_valid2), .out_payload(out_payload2), .out_side(out_side2),
        .skid_valid(skid_valid2), .overflow(overflow2), .cnt_clr(cnt_clr),
        .bubble_cnt(bubble_cnt2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] stall;
        logic          flush;
        logic          clr;
        logic          iv;
        logic [PW-1:0] ip;
        logic          is;
        logic          ev;
        logic [PW-1:0] ep;
        logic          es;
        logic          esk;
        logic          eov;
        logic [15:0]   ebub;
        logic [15:0]   estl;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    int n_vec;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [SW-1:0] s, input logic f, input logic c,
                         input logic iv, input logic [PW-1:0] ip, input logic is);
        stall = s; flush = f; cnt_clr = c;
        in_valid = iv; in_payload = ip; in_side = is;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //               stall      fl    clr   iv    ip        is    ev    ep        es    esk   eov   bub    stl
        vec[0]  = '{6'b000000, 1'b0, 1'b0, 1'b1, 16'h01A5, 1'b1, 1'b1, 16'h01A5, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vec[1]  = '{6'b000000, 1'b0, 1'b0, 1'b1, 16'h00AA, 1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vec[2]  = '{6'b000100, 1'b0, 1'b0, 1'b1, 16'h0111, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
        vec[3]  = '{6'b000100, 1'b0, 1'b0, 1'b1, 16'h0111, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0};
        vec[4]  = '{6'b000000, 1'b0, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0};
        vec[5]  = '{6'b001000, 1'b0, 1'b0, 1'b1, 16'h00BB, 1'b1, 1'b1, 16'h00AA, 1'b0, 1'b1, 1'b0, 16'd2, 16'd1};
        vec[6]  = '{6'b000000, 1'b0, 1'b0, 1'b1, 16'h00CC, 1'b0, 1'b1, 16'h00BB, 1'b1, 1'b1, 1'b0, 16'd2, 16'd1};
        vec[7]  = '{6'b000100, 1'b0, 1'b0, 1'b1, 16'h0111, 1'b1, 1'b1, 16'h00CC, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
        vec[8]  = '{6'b001000, 1'b0, 1'b0, 1'b1, 16'h00BB, 1'b1, 1'b1, 16'h00CC, 1'b0, 1'b1, 1'b0, 16'd2, 16'd2};
        vec[9]  = '{6'b001000, 1'b0, 1'b0, 1'b1, 16'h00CC, 1'b0, 1'b1, 16'h00CC, 1'b0, 1'b1, 1'b1, 16'd2, 16'd3};
        vec[10] = '{6'b000100, 1'b0, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b1, 16'h00BB, 1'b1, 1'b0, 1'b1, 16'd2, 16'd3};
        vec[11] = '{6'b001000, 1'b0, 1'b0, 1'b1, 16'h00DD, 1'b1, 1'b1, 16'h00BB, 1'b1, 1'b1, 1'b1, 16'd2, 16'd4};
        vec[12] = '{6'b001000, 1'b1, 1'b0, 1'b1, 16'h00DD, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd2, 16'd4};
        vec[13] = '{6'b000000, 1'b0, 1'b0, 1'b1, 16'h00EE, 1'b0, 1'b1, 16'h00EE, 1'b0, 1'b0, 1'b1, 16'd2, 16'd4};
        vec[14] = '{6'b001000, 1'b0, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b1, 16'h00EE, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
        vec[15] = '{6'b001100, 1'b0, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b1, 16'h00EE, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
        vec[16] = '{6'b000100, 1'b0, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1};
        vec[17] = '{6'b000000, 1'b0, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b1, 16'd0, 16'd1};
        vec[18] = '{6'b000100, 1'b0, 1'b0, 1'b1, 16'h0111, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};

        // Reset state while reset is held.
        rst = 1'b0;
        drive(6'b000000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk("reset out_valid",   32'(out_valid),   32'h0);
        chk("reset out_payload", 32'(out_payload), 32'h0);
        chk("reset out_side",    32'(out_side),    32'h0);
        chk("reset skid_valid",  32'(skid_valid),  32'h0);
        chk("reset overflow",    32'(overflow),    32'h0);
        chk("reset bubble_cnt",  32'(bubble_cnt),  32'h0);
        chk("reset stall_cnt",   32'(stall_cnt),   32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors: each vector is applied for one clock edge.
        for (int i = 0; i < NV; i++) begin
            drive(vec[i].stall, vec[i].flush, vec[i].clr, vec[i].iv, vec[i].ip, vec[i].is);
            @(posedge clk);
            #1;
            n_vec++;
            chk($sformatf("v%0d out_valid", i),   32'(out_valid),   32'(vec[i].ev));
            chk($sformatf("v%0d out_payload", i), 32'(out_payload), 32'(vec[i].ep));
            chk($sformatf("v%0d out_side", i),    32'(out_side),    32'(vec[i].es));
            chk($sformatf("v%0d skid_valid", i),  32'(skid_valid),  32'(vec[i].esk));
            chk($sformatf("v%0d overflow", i),    32'(overflow),    32'(vec[i].eov));
            chk($sformatf("v%0d bubble_cnt", i),  32'(bubble_cnt),  32'(vec[i].ebub));
            chk($sformatf("v%0d stall_cnt", i),   32'(stall_cnt),   32'(vec[i].estl));
        end

        // Counter clear together with a fresh valid entry.
        drive(6'b000000, 1'b0, 1'b1, 1'b1, 16'h0055, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        chk("clr out_payload",  32'(out_payload), 32'h55);
        chk("clr stall_cnt",    32'(stall_cnt),   32'h0);
        chk("clr sat stall",    32'(stall_cnt2),  32'h0);
        chk("clr sat bubble",   32'(bubble_cnt2), 32'h0);

        // Downstream stall for 5 cycles: narrow counter saturates at 3.
        drive(6'b011000, 1'b0, 1'b0, 1'b1, 16'h0066, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        chk("sat stall_cnt2",  32'(stall_cnt2),  32'h3);
        chk("sat stall_cnt",   32'(stall_cnt),   32'h5);
        chk("sat out_payload", 32'(out_payload), 32'h55);
        chk("sat skid_valid",  32'(skid_valid),  32'h1);

        // Clear wins over an increment in the same cycle.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        chk("clr-prio stall_cnt2", 32'(stall_cnt2), 32'h0);
        chk("clr-prio stall_cnt",  32'(stall_cnt),  32'h0);
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        chk("pre-rst out_valid", 32'(out_valid),  32'h1);
        chk("pre-rst stall_cnt", 32'(stall_cnt),  32'h1);

        // Asynchronous reset mid-cycle with the skid full.
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        chk("async out_valid",   32'(out_valid),   32'h0);
        chk("async out_payload", 32'(out_payload), 32'h0);
        chk("async out_side",    32'(out_side),    32'h0);
        chk("async skid_valid",  32'(skid_valid),  32'h0);
        chk("async overflow",    32'(overflow),    32'h0);
        chk("async stall_cnt",   32'(stall_cnt),   32'h0);
        chk("async stall_cnt2",  32'(stall_cnt2),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
